// File: rtl/rca_pkg.sv
// Shared types and helpers for the multi-cycle ripple-carry adder.
package rca_pkg;

  // Controller states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result of one half-adder cell.
  typedef struct packed {
    logic s;
    logic c;
  } ha_t;

  // Counter width helper: a one-slice adder still needs a 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Half-adder cell: the basic building block of every full adder.
  function automatic ha_t half_add(input logic x, input logic y);
    ha_t r;
    r.s = x ^ y;
    r.c = x & y;
    return r;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple adder. Each bit is a full adder made of
// two half-adder cells whose carries are ORed together.
module rca_slice
  import rca_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic w_carry;
  ha_t  w_h1;
  ha_t  w_h2;

  // Ripple the carry from bit 0 upward through the full-adder chain.
  always_comb begin
    w_carry = cin;
    w_h1    = '0;
    w_h2    = '0;
    s       = '0;
    for (int i = 0; i < SLICE; i++) begin
      w_h1    = half_add(a[i], b[i]);
      w_h2    = half_add(w_h1.s, w_carry);
      s[i]    = w_h2.s;
      w_carry = w_h1.c | w_h2.c;
    end
    cout = w_carry;
  end

endmodule

// File: rtl/rca_serial_adder.sv
// Multi-cycle ripple-carry adder: adds two WIDTH-bit operands SLICE bits per
// clock, linking slices through a registered carry.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; operands are captured on the
// input transfer and later input changes have no effect. out_valid is high
// only in DONE; Sum/Cout stay stable until the output transfer, after which
// out_valid drops on the next cycle. in_valid outside IDLE is ignored.
module rca_serial_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output state_t           o_dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = clog2_min1(NSLICE);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  // Reject parameter sets the slicing scheme cannot handle.
  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("rca_serial_adder: WIDTH must be >= 1 and a multiple of SLICE");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [SLICE-1:0] w_slice_s;
  logic             w_slice_c;
  logic [WIDTH-1:0] w_sum_shift;
  logic             w_last;

  // One slice adder, fed from the low end of the operand shift registers.
  rca_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_c)
  );

  assign w_last = (r_cnt == LAST_CNT);

  // New slice sum enters at the MSB end so the word lands aligned after NSLICE shifts.
  always_comb begin
    w_sum_shift = r_sum >> SLICE;
    w_sum_shift[WIDTH-1 -: SLICE] = w_slice_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, per-slice shifting, carry chaining and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_shift;
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_carry <= w_slice_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_cout <= w_slice_c;
        end
        default: ;
      endcase
    end
  end

  assign Sum         = r_sum;
  assign Cout        = r_cout;
  assign o_dbg_state = r_state;

endmodule
